// File: rtl/viterbi_frame_ctrl_pkg.sv
// Shared types and constants for the Viterbi frame controller.
// The optional first-error log is enabled with the VITERBI_FRAME_CTRL_ERRLOG_EN macro.
package viterbi_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        TAIL,
        DRAIN,
        DONE
    } vfc_state_t;

    // One delay-line entry: slot occupied, slot carries a payload bit, expected bit value.
    typedef struct packed {
        logic valid;
        logic data;
        logic exp;
    } vfc_tag_t;

    localparam logic [31:0] TOTAL_ERR_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/viterbi_frame_ctrl_if.sv
// Frame-side handshake and result bus of the Viterbi frame controller.
// first_err_pos_o/first_err_vld_o exist only when VITERBI_FRAME_CTRL_ERRLOG_EN is defined.
interface viterbi_frame_ctrl_if #(
    parameter int FRAME_LEN = 16
);
    localparam int ERR_W = $clog2(FRAME_LEN + 1);

    logic [FRAME_LEN-1:0] frame_data_i;
    logic                 frame_valid_i;
    logic                 frame_ready_o;
    logic                 abort_i;
    logic                 frame_done_o;
    logic [ERR_W-1:0]     frame_err_o;
    logic [31:0]          total_err_o;
    logic [15:0]          frame_cnt_o;

`ifdef VITERBI_FRAME_CTRL_ERRLOG_EN
    localparam int POS_W = $clog2(FRAME_LEN);

    logic [POS_W-1:0]     first_err_pos_o;
    logic                 first_err_vld_o;

    modport master (
        output frame_data_i, frame_valid_i, abort_i,
        input  frame_ready_o, frame_done_o, frame_err_o, total_err_o, frame_cnt_o,
        input  first_err_pos_o, first_err_vld_o
    );

    modport slave (
        input  frame_data_i, frame_valid_i, abort_i,
        output frame_ready_o, frame_done_o, frame_err_o, total_err_o, frame_cnt_o,
        output first_err_pos_o, first_err_vld_o
    );
`else
    modport master (
        output frame_data_i, frame_valid_i, abort_i,
        input  frame_ready_o, frame_done_o, frame_err_o, total_err_o, frame_cnt_o
    );

    modport slave (
        input  frame_data_i, frame_valid_i, abort_i,
        output frame_ready_o, frame_done_o, frame_err_o, total_err_o, frame_cnt_o
    );
`endif

endinterface

// File: rtl/viterbi_frame_ctrl_tag.sv
// viterbi_tag_delay: DEPTH-stage shift register of expected-bit tags that lines the
// encoder input up with the decoder output. flush empties every stage synchronously.
module viterbi_tag_delay
    import viterbi_ctrl_pkg::*;
#(
    parameter int DEPTH = 20
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    input  vfc_tag_t tag_in,
    output vfc_tag_t tag_out
);

    vfc_tag_t stages [DEPTH];

    // Shift one stage per cycle; flush and reset both leave the line holding empty slots.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else begin
            stages[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end

    assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl: serialises one frame word into the convolutional encoder, appends
// the trellis flush bits, and checks the decoder output against the sent bits.
// Define VITERBI_FRAME_CTRL_ERRLOG_EN to add the first-error position log.
module viterbi_frame_ctrl
    import viterbi_ctrl_pkg::*;
#(
    parameter int FRAME_LEN = 16,
    parameter int TAIL_LEN  = 2,
    parameter int DEC_LAT   = 20
) (
    input  logic                clk,
    input  logic                rst,
    viterbi_frame_ctrl_if.slave bus,
    output logic                enc_en_o,
    output logic                enc_bit_o,
    input  logic                dec_bit_i
);

    localparam int ERR_W     = $clog2(FRAME_LEN + 1);
    localparam int CNT_W     = $clog2(FRAME_LEN + TAIL_LEN + 1);
    localparam int TAIL_LAST = (TAIL_LEN > 0) ? TAIL_LEN - 1 : 0;

    vfc_state_t           state;
    logic [FRAME_LEN-2:0] shreg;
    logic [CNT_W-1:0]     bit_cnt;
    logic [ERR_W-1:0]     rx_cnt;
    logic [ERR_W-1:0]     err_cnt;
    logic [ERR_W-1:0]     frame_err_q;
    logic [31:0]          total_q;
    logic [31:0]          total_nxt;
    logic [15:0]          frame_cnt_q;
    logic                 ready_q;
    logic                 done_q;
    logic                 accept;
    logic                 abort_now;
    logic                 finish;
    logic                 tap_check;
    logic                 tap_miss;
    vfc_tag_t             tag_in;
    vfc_tag_t             tag_out;

    // Abort only matters mid-frame, and it blocks an accept presented in the same cycle.
    assign abort_now = bus.abort_i && (state != IDLE);
    assign accept    = (state == IDLE) && ready_q && bus.frame_valid_i && !bus.abort_i;
    assign finish    = (state == DRAIN) && (rx_cnt == ERR_W'(FRAME_LEN));

    // Tags ride alongside the registered encoder inputs; only SEND slots carry payload.
    assign tag_in    = '{valid: enc_en_o, data: (state == SEND), exp: enc_bit_o};
    assign tap_check = tag_out.valid && tag_out.data && !abort_now;
    assign tap_miss  = tap_check && (dec_bit_i != tag_out.exp);

    viterbi_tag_delay #(.DEPTH(DEC_LAT)) u_delay (
        .clk     (clk),
        .rst     (rst),
        .flush   (abort_now),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Frame sequencer: walks IDLE->SEND->TAIL->DRAIN->DONE and drives registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ready_q     <= 1'b1;
            enc_en_o    <= 1'b0;
            enc_bit_o   <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            done_q      <= 1'b0;
            frame_err_q <= '0;
            frame_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort_now) begin
                state     <= IDLE;
                ready_q   <= 1'b1;
                enc_en_o  <= 1'b0;
                enc_bit_o <= 1'b0;
                bit_cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            state     <= SEND;
                            ready_q   <= 1'b0;
                            shreg     <= bus.frame_data_i[FRAME_LEN-1:1];
                            enc_en_o  <= 1'b1;
                            enc_bit_o <= bus.frame_data_i[0];
                            bit_cnt   <= '0;
                        end
                    end
                    SEND: begin
                        if (bit_cnt == CNT_W'(FRAME_LEN - 1)) begin
                            bit_cnt   <= '0;
                            enc_bit_o <= 1'b0;
                            if (TAIL_LEN > 0) begin
                                state <= TAIL;
                            end else begin
                                state    <= DRAIN;
                                enc_en_o <= 1'b0;
                            end
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            shreg     <= shreg >> 1;
                            enc_bit_o <= shreg[0];
                        end
                    end
                    TAIL: begin
                        if (bit_cnt == CNT_W'(TAIL_LAST)) begin
                            state    <= DRAIN;
                            enc_en_o <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (finish) begin
                            state       <= DONE;
                            done_q      <= 1'b1;
                            frame_err_q <= err_cnt;
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                        end
                    end
                    DONE: begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end
                    default: begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Per-frame tallies restart with each new frame and are discarded on abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_cnt  <= '0;
            err_cnt <= '0;
        end else if (accept || abort_now) begin
            rx_cnt  <= '0;
            err_cnt <= '0;
        end else if (tap_check) begin
            rx_cnt <= rx_cnt + 1'b1;
            if (tap_miss) err_cnt <= err_cnt + 1'b1;
        end
    end

    // Cumulative error count sticks at its maximum instead of wrapping.
    always_comb begin
        total_nxt = total_q;
        if (tap_miss && (total_q != TOTAL_ERR_MAX)) total_nxt = total_q + 32'd1;
    end

    // Cumulative error register is reloaded every cycle from its next-value logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) total_q <= '0;
        else      total_q <= total_nxt;
    end

`ifdef VITERBI_FRAME_CTRL_ERRLOG_EN
    localparam int POS_W = $clog2(FRAME_LEN);

    logic [POS_W-1:0] first_pos;
    logic             first_seen;
    logic [POS_W-1:0] first_pos_q;
    logic             first_vld_q;

    // Remember where the first mismatch of the current frame fell; publish it on DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_pos   <= '0;
            first_seen  <= 1'b0;
            first_pos_q <= '0;
            first_vld_q <= 1'b0;
        end else begin
            if (accept || abort_now) begin
                first_pos  <= '0;
                first_seen <= 1'b0;
            end else if (tap_miss && !first_seen) begin
                first_pos  <= rx_cnt[POS_W-1:0];
                first_seen <= 1'b1;
            end
            if (finish && !abort_now) begin
                first_pos_q <= first_seen ? first_pos : '0;
                first_vld_q <= first_seen;
            end
        end
    end

    assign bus.first_err_pos_o = first_pos_q;
    assign bus.first_err_vld_o = first_vld_q;
`endif

    assign bus.frame_ready_o = ready_q;
    assign bus.frame_done_o  = done_q;
    assign bus.frame_err_o   = frame_err_q;
    assign bus.total_err_o   = total_q;
    assign bus.frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Scoreboard bench for viterbi_frame_ctrl: a channel model corrupts chosen encoder bits,
// the expected per-frame result is queued at accept time and checked on each done pulse.
module tb_viterbi_frame_ctrl;
    import viterbi_ctrl_pkg::*;

    localparam int FL = 16;
    localparam int TL = 2;
    localparam int DL = 20;

    typedef struct {
        int     err;
        longint total;
        int     cnt;
        int     first_pos;
        bit     first_vld;
        longint done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enc_en;
    logic enc_bit;
    logic dec_bit = 1'b0;

    int     checks = 0;
    int     fails = 0;
    longint cyc = 0;
    longint model_total = 0;
    int     model_cnt = 0;
    int     done_seen = 0;
    bit     in_flight = 1'b0;

    exp_t          sb_q[$];
    bit [FL-1:0]   mask_q[$];
    bit            tail_q[$];
    bit            chan_q[$];
    int            slot = 0;
    bit [FL-1:0]   cur_mask = '0;
    bit            cur_tail = 1'b0;

    viterbi_frame_ctrl_if #(.FRAME_LEN(FL)) bus();

    viterbi_frame_ctrl #(.FRAME_LEN(FL), .TAIL_LEN(TL), .DEC_LAT(DL)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .enc_en_o  (enc_en),
        .enc_bit_o (enc_bit),
        .dec_bit_i (dec_bit)
    );

    // Free-running clock and edge counter used for latency checks.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Ideal channel: decoder output equals encoder input DL cycles later, with chosen slots inverted.
    always @(negedge clk) begin : chan_blk
        bit s;
        s = enc_bit;
        if (enc_en) begin
            if (slot == 0) begin
                cur_mask = (mask_q.size() > 0) ? mask_q.pop_front() : '0;
                cur_tail = (tail_q.size() > 0) ? tail_q.pop_front() : 1'b0;
            end
            if (slot < FL) s = s ^ cur_mask[slot];
            else           s = s ^ cur_tail;
            slot++;
        end else begin
            slot = 0;
        end
        chan_q.push_back(s);
        if (chan_q.size() > DL) dec_bit = chan_q.pop_front();
    end

    // Monitor: ready must stay low while a frame is in flight; each done pulse pops one expectation.
    always @(negedge clk) begin : mon_blk
        exp_t e;
        if (in_flight) checkOutput("ready_in_flight", bus.frame_ready_o, 0);
        if (bus.frame_done_o) begin
            done_seen++;
            in_flight = 1'b0;
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                checkOutput("done_cycle", cyc, e.done_cyc);
                checkOutput("frame_err", bus.frame_err_o, e.err);
                checkOutput("total_err", bus.total_err_o, e.total);
                checkOutput("frame_cnt", bus.frame_cnt_o, e.cnt);
`ifdef VITERBI_FRAME_CTRL_ERRLOG_EN
                checkOutput("first_err_vld", bus.first_err_vld_o, e.first_vld);
                checkOutput("first_err_pos", bus.first_err_pos_o, e.first_pos);
`endif
            end
        end
    end

    // Reference model: errors are the corrupted payload bits; tail corruption never counts.
    task automatic noteAccept(input bit [FL-1:0] mask, input bit tail_c, input bit expect_done);
        exp_t   e;
        longint accept_edge;
        accept_edge = cyc + 1;
        mask_q.push_back(mask);
        tail_q.push_back(tail_c);
        if (expect_done) begin
            e.err = $countones(mask);
            model_total = model_total + e.err;
            if (model_total > longint'(TOTAL_ERR_MAX)) model_total = longint'(TOTAL_ERR_MAX);
            model_cnt = (model_cnt + 1) % 65536;
            e.total = model_total;
            e.cnt = model_cnt;
            e.first_pos = 0;
            e.first_vld = 1'b0;
            for (int i = FL - 1; i >= 0; i--) begin
                if (mask[i]) begin
                    e.first_pos = i;
                    e.first_vld = 1'b1;
                end
            end
            e.done_cyc = (DL > TL) ? accept_edge + FL + DL + 1 : accept_edge + FL + TL + 1;
            sb_q.push_back(e);
        end
    endtask

    task automatic applyStimulus(input bit [FL-1:0] word, input bit [FL-1:0] mask,
                                 input bit tail_c, input int abort_at);
        int w;
        w = 0;
        @(negedge clk);
        bus.frame_data_i  = word;
        bus.frame_valid_i = 1'b1;
        while (!bus.frame_ready_o && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!bus.frame_ready_o) begin
            checkOutput("ready_timeout", 0, 1);
            bus.frame_valid_i = 1'b0;
            return;
        end
        noteAccept(mask, tail_c, abort_at < 0);
        @(posedge clk);
        in_flight = 1'b1;
        @(negedge clk);
        bus.frame_valid_i = 1'b0;
        if (abort_at >= 0) begin
            repeat (abort_at) @(negedge clk);
            bus.abort_i = 1'b1;
            @(posedge clk);
            in_flight = 1'b0;
            @(negedge clk);
            bus.abort_i = 1'b0;
            checkOutput("abort_ready", bus.frame_ready_o, 1);
            checkOutput("abort_enc_en", enc_en, 0);
        end
    endtask

    task automatic waitDrain();
        int w;
        w = 0;
        while ((sb_q.size() > 0 || in_flight) && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (sb_q.size() > 0 || in_flight) begin
            checkOutput("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
            in_flight = 1'b0;
        end
    endtask

    task automatic runBackToBack();
        bit [FL-1:0] words [3];
        bit [FL-1:0] masks [3];
        int start_done;
        for (int i = 0; i < 3; i++) begin
            words[i] = FL'($urandom);
            masks[i] = FL'($urandom) & FL'($urandom) & FL'($urandom);
        end
        start_done = done_seen;
        @(negedge clk);
        bus.frame_data_i  = words[0];
        bus.frame_valid_i = 1'b1;
        for (int f = 0; f < 3; f++) begin
            int w;
            w = 0;
            while (!bus.frame_ready_o && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (!bus.frame_ready_o) begin
                checkOutput("b2b_ready_timeout", 0, 1);
                break;
            end
            noteAccept(masks[f], 1'b0, 1'b1);
            @(posedge clk);
            in_flight = 1'b1;
            @(negedge clk);
            if (f < 2) bus.frame_data_i = words[f+1];
            else       bus.frame_valid_i = 1'b0;
        end
        bus.frame_valid_i = 1'b0;
        waitDrain();
        checkOutput("b2b_done_pulses", done_seen - start_done, 3);
    endtask

    // Abort the run if the sequence stalls far beyond its expected length.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, fails=%0d", fails);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.frame_data_i  = '0;
        bus.frame_valid_i = 1'b0;
        bus.abort_i       = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", bus.frame_ready_o, 1);
        checkOutput("rst_enc_en", enc_en, 0);
        checkOutput("rst_enc_bit", enc_bit, 0);
        checkOutput("rst_done", bus.frame_done_o, 0);
        checkOutput("rst_frame_err", bus.frame_err_o, 0);
        checkOutput("rst_total", bus.total_err_o, 0);
        checkOutput("rst_frame_cnt", bus.frame_cnt_o, 0);
        rst = 1'b1;

        // Reset in the middle of SEND: frame dropped, no done pulse
        @(negedge clk);
        bus.frame_data_i  = 16'h1234;
        bus.frame_valid_i = 1'b1;
        @(posedge clk);
        in_flight = 1'b1;
        @(negedge clk);
        bus.frame_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        in_flight = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_ready", bus.frame_ready_o, 1);
        checkOutput("midrst_enc_en", enc_en, 0);
        checkOutput("midrst_done", bus.frame_done_o, 0);
        rst = 1'b1;
        model_total = 0;
        model_cnt = 0;
        repeat (45) @(negedge clk);
        checkOutput("midrst_frame_cnt", bus.frame_cnt_o, 0);

        // Clean frame, then the same frame with decoded bits 3 and 9 inverted
        applyStimulus(16'hA5C3, 16'h0000, 1'b0, -1);
        waitDrain();
        applyStimulus(16'hA5C3, 16'h0208, 1'b0, -1);
        waitDrain();

        // Corruption confined to the flush-bit slots must not count
        applyStimulus(16'h5A3C, 16'h0000, 1'b1, -1);
        waitDrain();

        // Abort at SEND bit 5, then a clean frame
        applyStimulus(16'hFFFF, 16'h0000, 1'b0, 5);
        repeat (45) @(negedge clk);
        applyStimulus(16'h0F0F, 16'h0000, 1'b0, -1);
        waitDrain();

        // Randomized frames with sparse error patterns
        for (int i = 0; i < 6; i++) begin
            applyStimulus(FL'($urandom), FL'($urandom) & FL'($urandom) & FL'($urandom),
                          1'($urandom), -1);
            waitDrain();
        end

        // Valid held high across three frames
        runBackToBack();

        // Saturation of the cumulative counter from a preloaded near-maximum value
        @(negedge clk);
        force dut.total_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.total_q;
        model_total = 64'h0000_0000_FFFF_FFFE;
        applyStimulus(16'hC0DE, 16'h8421, 1'b0, -1);
        waitDrain();
        applyStimulus(16'hBEEF, 16'h0010, 1'b0, -1);
        waitDrain();

        repeat (5) @(negedge clk);
        checkOutput("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", checks, fails);
        $finish;
    end

endmodule
